// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch: CH_NUM-channel PWM generator sharing one period counter.
// Period and per-channel duty are double-buffered (pending -> active) so
// that new values only take effect at a period boundary.
//
// Ports:
//   sys_clk        system clock (50 MHz)
//   sys_rst        synchronous, active-high reset
//   cfg_wr         single-cycle write strobe
//   cfg_is_period  1: write period, 0: write duty of cfg_ch
//   cfg_ch         channel index of a duty write (>= CH_NUM ignored)
//   cfg_data       write data
//   ch_en          live per-channel enable
//   center_mode    center-aligned select (PWM_CENTER_EN builds only)
//   pwm_out        registered PWM outputs, idle level = INV_MASK
//   period_tick    one-cycle pulse while pwm_out reflects cnt == 0
//
// Build option: define PWM_CENTER_EN to generate the up/down
// (center-aligned) counter. Without it center_mode is ignored.

module pwm_multi_ch #(
  parameter int                CH_NUM     = 4,
  parameter int                CNT_W      = 16,
  parameter int                DEF_PERIOD = 50000,
  parameter int                DEF_DUTY   = 25000,
  parameter logic [CH_NUM-1:0] INV_MASK   = '0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              cfg_wr,
  input  logic              cfg_is_period,
  input  logic [3:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_data,
  input  logic [CH_NUM-1:0] ch_en,
  input  logic              center_mode,
  output logic [CH_NUM-1:0] pwm_out,
  output logic              period_tick
);

  localparam int DEF_P_CL = (DEF_PERIOD < 2) ? 2 : DEF_PERIOD;

  localparam logic [CNT_W-1:0] RST_PER  = CNT_W'(DEF_P_CL);
  localparam logic [CNT_W-1:0] RST_DUTY = CNT_W'(DEF_DUTY);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] per_act;
  logic [CNT_W-1:0] per_pend;
  logic [CNT_W-1:0] per_last;
  logic [CNT_W-1:0] wr_per;
  logic [CNT_W-1:0] duty_act  [CH_NUM];
  logic [CNT_W-1:0] duty_pend [CH_NUM];

  logic              load;
  logic              per_wr;
  logic [CH_NUM-1:0] duty_wr;
  logic [CH_NUM-1:0] pwm_nxt;

  assign per_last = per_act - ONE;

  // Periods below 2 would leave no room for a wrap; store them as 2.
  assign wr_per = (cfg_data < TWO) ? TWO : cfg_data;

  assign per_wr = cfg_wr & cfg_is_period;

  // Per-channel write decode; indices >= CH_NUM match nothing.
  always_comb begin
    duty_wr = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      duty_wr[i] = cfg_wr & ~cfg_is_period
                 & (cfg_ch == 4'(i));
    end
  end

`ifdef PWM_CENTER_EN

  logic mode_act;
  logic dir_dn;
  logic dir_nxt;

  // Center mode: up 0..P-1, down P-2..1, shadow load at the
  // down-count 1. With P == 2 there is no down leg, so the top
  // of the up leg is also the load point.
  always_comb begin
    load    = 1'b0;
    cnt_nxt = cnt + ONE;
    dir_nxt = dir_dn;
    if (mode_act) begin
      if (dir_dn) begin
        if (cnt <= ONE) begin
          load    = 1'b1;
          cnt_nxt = '0;
          dir_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end else if (cnt >= per_last) begin
        if (per_act == TWO) begin
          load    = 1'b1;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = per_act - TWO;
          dir_nxt = 1'b1;
        end
      end
    end else if (cnt >= per_last) begin
      load    = 1'b1;
      cnt_nxt = '0;
      dir_nxt = 1'b0;
    end
  end

  // Mode only switches at a shadow-load point so a period is never
  // split between the two counting schemes.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      mode_act <= 1'b0;
      dir_dn   <= 1'b0;
    end else begin
      dir_dn <= dir_nxt;
      if (load) begin
        mode_act <= center_mode;
      end
    end
  end

`else

  logic unused_center;
  assign unused_center = center_mode;

  always_comb begin
    load    = 1'b0;
    cnt_nxt = cnt + ONE;
    if (cnt >= per_last) begin
      load    = 1'b1;
      cnt_nxt = '0;
    end
  end

`endif

  // Channel compare against the active duty; ch_en acts immediately.
  always_comb begin
    pwm_nxt = INV_MASK;
    for (int i = 0; i < CH_NUM; i++) begin
      if (ch_en[i]) begin
        pwm_nxt[i] = (cnt < duty_act[i]) ^ INV_MASK[i];
      end
    end
  end

  // Counter and output registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt         <= '0;
      pwm_out     <= INV_MASK;
      period_tick <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      pwm_out     <= pwm_nxt;
      period_tick <= (cnt == '0);
    end
  end

  // Period shadow register. A write on the load cycle bypasses
  // pending so it governs the very next period.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      per_pend <= RST_PER;
      per_act  <= RST_PER;
    end else begin
      if (load) begin
        per_act <= per_pend;
      end
      if (per_wr) begin
        per_pend <= wr_per;
        if (load) begin
          per_act <= wr_per;
        end
      end
    end
  end

  // Duty shadow registers, same bypass rule as the period.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < CH_NUM; i++) begin
        duty_pend[i] <= RST_DUTY;
        duty_act[i]  <= RST_DUTY;
      end
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (load) begin
          duty_act[i] <= duty_pend[i];
        end
        if (duty_wr[i]) begin
          duty_pend[i] <= cfg_data;
          if (load) begin
            duty_act[i] <= cfg_data;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// tb_pwm_multi_ch: scoreboard bench for pwm_multi_ch
// (CNT_W=8, CH_NUM=4, P=10, D=5, INV_MASK=4'b0010).

module tb_pwm_multi_ch;

  localparam logic [3:0] INV = 4'b0010;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       cfg_wr;
  logic       cfg_is_period;
  logic [3:0] cfg_ch;
  logic [7:0] cfg_data;
  logic [3:0] ch_en;
  logic       center_mode;
  logic [3:0] pwm_out;
  logic       period_tick;

  int n_vec = 0;
  int n_bad = 0;

  logic [4:0] sb_q [$];
  logic [4:0] got;
  logic [4:0] exp_v;
  int         exp_d [4];

  pwm_multi_ch #(
    .CH_NUM    (4),
    .CNT_W     (8),
    .DEF_PERIOD(10),
    .DEF_DUTY  (5),
    .INV_MASK  (INV)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .cfg_wr       (cfg_wr),
    .cfg_is_period(cfg_is_period),
    .cfg_ch       (cfg_ch),
    .cfg_data     (cfg_data),
    .ch_en        (ch_en),
    .center_mode  (center_mode),
    .pwm_out      (pwm_out),
    .period_tick  (period_tick)
  );

  always #10 sys_clk = ~sys_clk;

  // Expected {period_tick, pwm_out} for an output showing count c.
  function automatic logic [4:0] expv(int c, logic [3:0] en);
    logic [4:0] r;
    r[4] = (c == 0);
    for (int i = 0; i < 4; i++) begin
      r[i] = en[i] ? ((c < exp_d[i]) ^ INV[i]) : INV[i];
    end
    return r;
  endfunction

  task automatic step();
    @(posedge sys_clk);
    @(negedge sys_clk);
    cfg_wr        = 1'b0;
    cfg_is_period = 1'b0;
  endtask

  task automatic do_reset();
    sys_rst       = 1'b1;
    cfg_wr        = 1'b0;
    cfg_is_period = 1'b0;
    cfg_ch        = '0;
    cfg_data      = '0;
    ch_en         = 4'hF;
    center_mode   = 1'b0;
    step();
    step();
    sys_rst = 1'b0;
    for (int i = 0; i < 4; i++) exp_d[i] = 5;
  endtask

  task automatic test_reset();
    do_reset();
    sb_q.push_back({1'b0, INV});
    got   = {period_tick, pwm_out};
    exp_v = sb_q.pop_front();
    n_vec++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL reset_state got=%b exp=%b", got, exp_v);
    end
    for (int c = 0; c < 20; c++) begin
      sb_q.push_back(expv(c % 10, ch_en));
      step();
      got   = {period_tick, pwm_out};
      exp_v = sb_q.pop_front();
      n_vec++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL reset_run c=%0d got=%b exp=%b", c, got, exp_v);
      end
    end
  endtask

  task automatic test_duty_mid();
    do_reset();
    for (int c = 0; c < 30; c++) begin
      if (c == 4) begin
        cfg_wr   = 1'b1;
        cfg_ch   = 4'd2;
        cfg_data = 8'd3;
      end
      if (c == 10) exp_d[2] = 3;
      sb_q.push_back(expv(c % 10, ch_en));
      step();
      got   = {period_tick, pwm_out};
      exp_v = sb_q.pop_front();
      n_vec++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL duty_mid c=%0d got=%b exp=%b", c, got, exp_v);
      end
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    for (int c = 0; c < 30; c++) begin
      if (c == 2) begin
        cfg_wr   = 1'b1;
        cfg_ch   = 4'd3;
        cfg_data = 8'd0;
      end
      if (c == 9) begin
        cfg_wr   = 1'b1;
        cfg_ch   = 4'd0;
        cfg_data = 8'd10;
      end
      if (c == 10) begin
        exp_d[3] = 0;
        exp_d[0] = 10;
      end
      sb_q.push_back(expv(c % 10, ch_en));
      step();
      got   = {period_tick, pwm_out};
      exp_v = sb_q.pop_front();
      n_vec++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL same_cycle c=%0d got=%b exp=%b", c, got, exp_v);
      end
    end
  endtask

  task automatic test_period_clamp();
    int ph;
    do_reset();
    for (int c = 0; c < 22; c++) begin
      if (c == 3) begin
        cfg_wr        = 1'b1;
        cfg_is_period = 1'b1;
        cfg_data      = 8'd1;
      end
      if (c == 5) begin
        cfg_wr   = 1'b1;
        cfg_ch   = 4'd5;
        cfg_data = 8'd0;
      end
      ph = (c < 10) ? c : (c - 10) % 2;
      sb_q.push_back(expv(ph, ch_en));
      step();
      got   = {period_tick, pwm_out};
      exp_v = sb_q.pop_front();
      n_vec++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL period_clamp c=%0d got=%b exp=%b", c, got, exp_v);
      end
    end
  endtask

  task automatic test_en_reset();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      if (c == 2) ch_en = 4'b1101;
      if (c == 3) begin
        cfg_wr   = 1'b1;
        cfg_ch   = 4'd0;
        cfg_data = 8'd2;
      end
      sb_q.push_back(expv(c, ch_en));
      step();
      got   = {period_tick, pwm_out};
      exp_v = sb_q.pop_front();
      n_vec++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL en_drop c=%0d got=%b exp=%b", c, got, exp_v);
      end
    end
    sys_rst = 1'b1;
    sb_q.push_back({1'b0, INV});
    step();
    sys_rst = 1'b0;
    ch_en   = 4'hF;
    got     = {period_tick, pwm_out};
    exp_v   = sb_q.pop_front();
    n_vec++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL mid_reset got=%b exp=%b", got, exp_v);
    end
    for (int c = 0; c < 20; c++) begin
      sb_q.push_back(expv(c % 10, ch_en));
      step();
      got   = {period_tick, pwm_out};
      exp_v = sb_q.pop_front();
      n_vec++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL post_reset c=%0d got=%b exp=%b", c, got, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    int ph;
    do_reset();
    for (int c = 0; c < 26; c++) begin
      if (c >= 5 && c <= 7) begin
        cfg_wr = 1'b1;
        cfg_ch = 4'(c - 5);
      end
      if (c == 5) cfg_data = 8'd1;
      if (c == 6) cfg_data = 8'd7;
      if (c == 7) cfg_data = 8'd9;
      if (c == 8) begin
        cfg_wr        = 1'b1;
        cfg_is_period = 1'b1;
        cfg_data      = 8'd8;
      end
      if (c == 10) begin
        exp_d[0] = 1;
        exp_d[1] = 7;
        exp_d[2] = 9;
      end
      ph = (c < 10) ? c : (c - 10) % 8;
      sb_q.push_back(expv(ph, ch_en));
      step();
      got   = {period_tick, pwm_out};
      exp_v = sb_q.pop_front();
      n_vec++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL back_to_back c=%0d got=%b exp=%b", c, got, exp_v);
      end
    end
  endtask

`ifdef PWM_CENTER_EN
  task automatic test_center();
    int k;
    int cv;
    do_reset();
    center_mode = 1'b1;
    for (int c = 0; c < 46; c++) begin
      if (c < 10) begin
        cv = c;
      end else begin
        k  = (c - 10) % 18;
        cv = (k < 10) ? k : 18 - k;
      end
      sb_q.push_back(expv(cv, ch_en));
      step();
      got   = {period_tick, pwm_out};
      exp_v = sb_q.pop_front();
      n_vec++;
      if (got !== exp_v) begin
        n_bad++;
        $display("FAIL center c=%0d got=%b exp=%b", c, got, exp_v);
      end
    end
    center_mode = 1'b0;
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_duty_mid();
    test_same_cycle();
    test_period_clamp();
    test_en_reset();
    test_back_to_back();
`ifdef PWM_CENTER_EN
    test_center();
`endif
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_left got=%0d exp=0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_multi_ch.md
Name: pwm_multi_ch

Overview:
Multi-channel PWM generator for the sys_clk domain (50 MHz). It generalises the single-channel, fixed-duty PWM to CH_NUM channels that share one period counter. Period and per-channel duty are runtime-programmable, and new values only take effect at period boundaries (glitch-free). Each channel has its own enable and a parameterised output polarity. It sits between the key/control logic and the LED and motor pins.

Parameters:
CH_NUM, 4, number of PWM channels (1..16)
CNT_W, 16, width of the counter, period and duty registers
DEF_PERIOD, 50000, period loaded at reset (1 kHz at 50 MHz); must be below 2^CNT_W
DEF_DUTY, 25000, duty loaded into every channel at reset
INV_MASK, {CH_NUM{1'b0}}, per-channel output inversion; bit i=1 makes channel i active-low

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst  in  1  synchronous, active-high reset
cfg_wr  in  1  single-cycle write strobe
cfg_is_period  in  1  1 = write period (cfg_ch ignored); 0 = write duty of cfg_ch
cfg_ch  in  4  channel index for a duty write
cfg_data  in  CNT_W  write data
ch_en  in  CH_NUM  live per-channel enable
center_mode  in  1  center-aligned select; only honoured with PWM_CENTER_EN
pwm_out  out  CH_NUM  registered PWM outputs
period_tick  out  1  one-cycle pulse at each period start

Behaviour:
- Clocking and reset:
  - Single clock, sys_clk. Reset is synchronous, active-high, named sys_rst.
  - All state is updated on the rising edge of sys_clk.
  - On reset: cnt=0; pending and active period=DEF_PERIOD; all pending and active duty=DEF_DUTY; pwm_out=INV_MASK (idle level); period_tick=0.
  - Reset asserted mid-period takes effect on the next edge. The current period is discarded and any pending writes are lost.
- Registers:
  - A write with cfg_wr=1 updates a pending register on the next edge.
  - A duty write with cfg_ch>=CH_NUM is ignored.
  - Active registers load from pending on the last-count cycle, i.e. the edge where cnt==P-1 (P = active period).
  - A write arriving on that same cycle goes directly into active, so its value governs the next period.
- Period clamp: a programmed period value below 2 is treated as 2.
- Edge-aligned counting (default):
  - cnt runs 0,1,...,P-1, then wraps to 0.
  - Free-running; unaffected by ch_en.
- Channel output:
  - raw_i = (cnt < D_i), where D_i is the active duty of channel i.
  - pwm_out[i] <= ch_en[i] ? raw_i ^ INV_MASK[i] : INV_MASK[i].
  - Latency: 1 cycle from cnt to pwm_out.
  - D_i=0: output stays inactive for the whole period.
  - D_i>=P: output stays active for the whole period (100%).
  - Comparison is unsigned, full CNT_W width; no overflow is possible.
- ch_en timing:
  - Deasserting ch_en forces the idle level on the next edge, mid-period, with no boundary wait.
  - Reasserting ch_en resumes the compare immediately against the current cnt.
- period_tick: registered; high for exactly the one cycle in which pwm_out reflects cnt==0.

Optional Feature:
PWM_CENTER_EN
- Defined, with center_mode=1:
  - cnt counts up 0..P-1, then down P-2..1, then back to 0. The full period is 2P-2 cycles.
  - The output is symmetric about the peak.
  - Shadow load happens on the cycle where cnt==1 while counting down.
  - period_tick is asserted at cnt==0.
  - A change of center_mode is sampled only at the shadow-load point.
- Defined, with center_mode=0: identical to the not-defined behaviour below.
- Not defined: center_mode is ignored; edge-aligned only. The logic for direction and down-counting is not generated.

Test Plan:
- Setup for all scenarios: CNT_W=8, CH_NUM=4, DEF_PERIOD=10, DEF_DUTY=5, INV_MASK=4'b0010, ch_en=4'hF.
- Reset release: pwm_out[0] repeats 5 cycles high then 5 cycles low; pwm_out[1] is the inverse; period_tick fires every 10 cycles.
- Write duty ch2=3 at cnt==4: the current period keeps 5 high; from the next period_tick, ch2 is high for 3 cycles.
- Write duty ch3=0, and ch0=10 on the last-count cycle: from the next period, ch3 is constantly low and ch0 constantly high (the same-cycle write is taken).
- Write period=1: it is clamped to 2, so period_tick fires every 2 cycles; a write with cfg_ch=5 changes nothing.
- Drop ch_en[1] mid-high: pwm_out[1] goes to 1 (idle, inverted) on the next edge; sys_rst pulsed at cnt==7: cnt restarts at 0, defaults are restored and pending writes are lost.
- With PWM_CENTER_EN and center_mode=1, P=10, D=5: period is 18 cycles; ch0 is high for cnt 0..4 (up) and 4..1 (down), i.e. 9 cycles, symmetric about the peak.
